// File: rtl/imm_pkg.sv
// Shared immediate-mode encoding and default widths for decode, the extender and the golden model.
package imm_pkg;

    typedef enum logic [1:0] {
        IMM_ZEXT = 2'b00,
        IMM_SEXT = 2'b01,
        IMM_PFX  = 2'b10
    } imm_mode_t;

    localparam int unsigned IMM_W_DEF  = 4;
    localparam int unsigned DATA_W_DEF = 8;

endpackage

// File: rtl/imm_prefix_extend_if.sv
// Decode-side and consumer-side valid/ready bus of the immediate extender.
interface imm_prefix_extend_if
    import imm_pkg::*;
#(
    parameter int unsigned IMM_W  = IMM_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
);
    logic              in_valid;
    logic              in_ready;
    logic [IMM_W-1:0]  imm_in;
    logic [1:0]        mode;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] imm_out;
    logic              pfx_ovf;

    modport master (
        output in_valid, imm_in, mode, out_ready,
        input  in_ready, out_valid, imm_out, pfx_ovf
    );

    modport slave (
        input  in_valid, imm_in, mode, out_ready,
        output in_ready, out_valid, imm_out, pfx_ovf
    );
endinterface

// File: rtl/imm_ext_core.sv
// Combinational extender: joins accumulated prefix chunks with the final immediate and
// zero- or sign-extends above the effective width (cnt+1)*IMM_W.
module imm_ext_core
    import imm_pkg::*;
#(
    parameter  int unsigned IMM_W   = IMM_W_DEF,
    parameter  int unsigned DATA_W  = DATA_W_DEF,
    localparam int unsigned ACC_W   = DATA_W - IMM_W,
    localparam int unsigned MAX_PFX = DATA_W / IMM_W - 1,
    localparam int unsigned CNT_W   = $clog2(MAX_PFX + 1)
) (
    input  logic [ACC_W-1:0]  i_acc,
    input  logic [CNT_W-1:0]  i_cnt,
    input  logic [IMM_W-1:0]  i_imm,
    input  logic              i_sext,
    output logic [DATA_W-1:0] o_result
);
    logic [DATA_W-1:0] w_v;
    int unsigned       w_ew;
    logic              w_sign;

    assign w_v = {i_acc, i_imm};

    always_comb begin
        w_ew   = (32'(i_cnt) + 32'd1) * IMM_W;
        w_sign = 1'b0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            if (i + 1 == w_ew) begin
                w_sign = w_v[i];
            end
        end
        // Bits above the effective width are known zero in w_v, so only sign fill is needed.
        for (int unsigned i = 0; i < DATA_W; i++) begin
            o_result[i] = (i < w_ew) ? w_v[i] : (i_sext & w_sign);
        end
    end

endmodule

// File: rtl/imm_prefix_extend.sv
// Immediate generator: accumulates prefix chunks, extends the final beat and registers the
// result behind a single-entry valid/ready output stage.
module imm_prefix_extend
    import imm_pkg::*;
#(
    parameter int unsigned IMM_W  = IMM_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input logic                clk,
    input logic                rst_n,
    input logic                flush,
    imm_prefix_extend_if.slave bus
);
    localparam int unsigned ACC_W   = DATA_W - IMM_W;
    localparam int unsigned MAX_PFX = DATA_W / IMM_W - 1;
    localparam int unsigned CNT_W   = $clog2(MAX_PFX + 1);

    if ((DATA_W % IMM_W) != 0 || DATA_W <= IMM_W) begin : g_bad_params
        $error("imm_prefix_extend: DATA_W must be a multiple of IMM_W and larger than it");
    end

    logic [ACC_W-1:0]  r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_ovf;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_imm_out;
    logic              r_pfx_ovf;

    logic              w_in_ready;
    logic              w_accept;
    logic              w_is_pfx;
    logic              w_sext;
    logic [DATA_W-1:0] w_result;

    assign w_in_ready = !flush && (!r_out_valid || bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_is_pfx   = (bus.mode == IMM_PFX);
    // Reserved encoding 2'b11 falls through to zero-extend.
    assign w_sext     = (bus.mode == IMM_SEXT);

    imm_ext_core #(
        .IMM_W  (IMM_W),
        .DATA_W (DATA_W)
    ) u_core (
        .i_acc    (r_acc),
        .i_cnt    (r_cnt),
        .i_imm    (bus.imm_in),
        .i_sext   (w_sext),
        .o_result (w_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_imm_out   <= '0;
            r_pfx_ovf   <= 1'b0;
        end else if (flush) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_accept && !w_is_pfx) begin
            r_out_valid <= 1'b1;
            r_imm_out   <= w_result;
            r_pfx_ovf   <= r_ovf;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
        end else begin
            if (w_accept) begin
                // Shifting left drops the oldest chunk once the accumulator is full.
                r_acc <= ACC_W'({r_acc, bus.imm_in});
                if (r_cnt < CNT_W'(MAX_PFX)) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end else begin
                    r_ovf <= 1'b1;
                end
            end
            if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.imm_out   = r_imm_out;
    assign bus.pfx_ovf   = r_pfx_ovf;

endmodule

// File: tb/tb_imm_prefix_extend.sv
// Self-checking bench: directed scenarios with literal expectations, then random traffic
// compared every cycle against a chunk-queue reference model.
module tb_imm_prefix_extend;
    import imm_pkg::*;

    localparam int unsigned IMM_W   = IMM_W_DEF;
    localparam int unsigned DATA_W  = DATA_W_DEF;
    localparam int unsigned MAX_PFX = DATA_W / IMM_W - 1;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;

    imm_prefix_extend_if #(.IMM_W(IMM_W), .DATA_W(DATA_W)) bus ();

    imm_prefix_extend #(
        .IMM_W  (IMM_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    // Reference state: prefix chunks seen since the last final beat, and the output register.
    int              m_q[$];
    bit              m_valid;
    longint unsigned m_imm;
    bit              m_ovf;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic void model_final(input int imm, input bit sext,
                                        output longint unsigned val, output bit ovf);
        int used;
        int ew;
        used = (m_q.size() > int'(MAX_PFX)) ? int'(MAX_PFX) : m_q.size();
        val  = 0;
        for (int i = m_q.size() - used; i < m_q.size(); i++) begin
            val = val * (64'd1 << IMM_W) + longint'(m_q[i]);
        end
        val = val * (64'd1 << IMM_W) + longint'(imm);
        ew  = (used + 1) * int'(IMM_W);
        if (sext && ew < int'(DATA_W) && val[ew-1]) begin
            val = val | (((64'd1 << DATA_W) - 1) ^ ((64'd1 << ew) - 1));
        end
        ovf = m_q.size() > int'(MAX_PFX);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit rdy;
        bit acc;
        if (!rst_n) begin
            m_q.delete();
            m_valid = 1'b0;
            m_imm   = 0;
            m_ovf   = 1'b0;
        end else if (flush) begin
            m_q.delete();
            m_valid = 1'b0;
        end else begin
            rdy = !m_valid || bus.out_ready;
            acc = bus.in_valid && rdy;
            if (acc && bus.mode != IMM_PFX) begin
                model_final(int'(bus.imm_in), bus.mode == IMM_SEXT, m_imm, m_ovf);
                m_valid = 1'b1;
                m_q.delete();
            end else begin
                if (acc) m_q.push_back(int'(bus.imm_in));
                if (bus.out_ready) m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en && rst_n) begin
            chk("cyc_out_valid", 64'(bus.out_valid), 64'(m_valid));
            chk("cyc_in_ready", 64'(bus.in_ready), 64'(!flush && (!m_valid || bus.out_ready)));
            if (m_valid) begin
                chk("cyc_imm_out", 64'(bus.imm_out), m_imm);
                chk("cyc_pfx_ovf", 64'(bus.pfx_ovf), 64'(m_ovf));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [1:0] m, input logic [IMM_W-1:0] d,
                         input bit rdy);
        bus.in_valid  = v;
        bus.mode      = m;
        bus.imm_in    = d;
        bus.out_ready = rdy;
    endtask

    initial begin
        rst_n = 1'b1;
        flush = 1'b0;
        drive(1'b0, IMM_ZEXT, 4'h0, 1'b1);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_imm_out", 64'(bus.imm_out), 64'd0);
        chk("rst_pfx_ovf", 64'(bus.pfx_ovf), 64'd0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        tick();

        // ZEXT single beat
        drive(1'b1, IMM_ZEXT, 4'hA, 1'b1);
        tick();
        chk("t1_valid", 64'(bus.out_valid), 64'd1);
        chk("t1_imm", 64'(bus.imm_out), 64'h0A);
        chk("t1_ovf", 64'(bus.pfx_ovf), 64'd0);
        drive(1'b0, IMM_ZEXT, 4'h0, 1'b1);
        tick();
        chk("t1_drop", 64'(bus.out_valid), 64'd0);

        // Back-to-back SEXT
        drive(1'b1, IMM_SEXT, 4'hA, 1'b1);
        tick();
        chk("t2_imm_a", 64'(bus.imm_out), 64'hFA);
        drive(1'b1, IMM_SEXT, 4'h5, 1'b1);
        tick();
        chk("t2_valid_b", 64'(bus.out_valid), 64'd1);
        chk("t2_imm_b", 64'(bus.imm_out), 64'h05);
        drive(1'b0, IMM_ZEXT, 4'h0, 1'b1);
        tick();

        // One prefix fills the width exactly
        drive(1'b1, IMM_PFX, 4'h8, 1'b1);
        tick();
        chk("t3_no_out", 64'(bus.out_valid), 64'd0);
        drive(1'b1, IMM_SEXT, 4'h3, 1'b1);
        tick();
        chk("t3_imm", 64'(bus.imm_out), 64'h83);
        chk("t3_ovf", 64'(bus.pfx_ovf), 64'd0);
        drive(1'b0, IMM_ZEXT, 4'h0, 1'b1);
        tick();

        // Prefix overflow, then flag clears
        drive(1'b1, IMM_PFX, 4'h1, 1'b1);
        tick();
        drive(1'b1, IMM_PFX, 4'h2, 1'b1);
        tick();
        drive(1'b1, IMM_ZEXT, 4'h3, 1'b1);
        tick();
        chk("t4_imm", 64'(bus.imm_out), 64'h23);
        chk("t4_ovf", 64'(bus.pfx_ovf), 64'd1);
        drive(1'b1, IMM_ZEXT, 4'h4, 1'b1);
        tick();
        chk("t4_imm2", 64'(bus.imm_out), 64'h04);
        chk("t4_ovf2", 64'(bus.pfx_ovf), 64'd0);
        drive(1'b0, IMM_ZEXT, 4'h0, 1'b1);
        tick();

        // Backpressure
        drive(1'b1, IMM_ZEXT, 4'h1, 1'b0);
        tick();
        chk("t5_imm1", 64'(bus.imm_out), 64'h01);
        drive(1'b1, IMM_ZEXT, 4'h2, 1'b0);
        #1;
        chk("t5_stall", 64'(bus.in_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_hold_imm", 64'(bus.imm_out), 64'h01);
            chk("t5_hold_valid", 64'(bus.out_valid), 64'd1);
        end
        drive(1'b1, IMM_ZEXT, 4'h2, 1'b1);
        #1;
        chk("t5_release", 64'(bus.in_ready), 64'd1);
        tick();
        chk("t5_imm2", 64'(bus.imm_out), 64'h02);
        chk("t5_valid2", 64'(bus.out_valid), 64'd1);
        drive(1'b0, IMM_ZEXT, 4'h0, 1'b1);
        tick();
        chk("t5_drain", 64'(bus.out_valid), 64'd0);

        // Flush discards the prefix and blocks the concurrent beat
        drive(1'b1, IMM_PFX, 4'hF, 1'b1);
        tick();
        flush = 1'b1;
        drive(1'b1, IMM_SEXT, 4'h3, 1'b1);
        #1;
        chk("t6a_flush_rdy", 64'(bus.in_ready), 64'd0);
        tick();
        flush = 1'b0;
        chk("t6a_flush_valid", 64'(bus.out_valid), 64'd0);
        tick();
        chk("t6a_imm", 64'(bus.imm_out), 64'h03);
        drive(1'b0, IMM_ZEXT, 4'h0, 1'b1);
        tick();

        // Asynchronous reset mid-prefix
        drive(1'b1, IMM_PFX, 4'hF, 1'b1);
        tick();
        drive(1'b0, IMM_ZEXT, 4'h0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6b_rst_imm", 64'(bus.imm_out), 64'd0);
        chk("t6b_rst_valid", 64'(bus.out_valid), 64'd0);
        chk("t6b_rst_ovf", 64'(bus.pfx_ovf), 64'd0);
        #2 rst_n = 1'b1;
        drive(1'b1, IMM_ZEXT, 4'h3, 1'b1);
        tick();
        chk("t6b_imm", 64'(bus.imm_out), 64'h03);
        chk("t6b_ovf", 64'(bus.pfx_ovf), 64'd0);
        drive(1'b0, IMM_ZEXT, 4'h0, 1'b1);
        tick();

        // Random traffic, including reserved mode and flushes
        for (int n = 0; n < 800; n++) begin
            flush = ($urandom_range(0, 19) == 0);
            drive($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)), IMM_W'($urandom),
                  $urandom_range(0, 9) < 7);
            tick();
        end
        flush = 1'b0;
        drive(1'b0, IMM_ZEXT, 4'h0, 1'b1);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_prefix_extend.md
Name: imm_prefix_extend

Overview:
Parametrised immediate generator for the simple-ISA CPU. It extends short instruction immediates to the datapath width, in zero-extend or sign-extend mode. It also supports prefix instructions that accumulate upper immediate chunks across several beats. It sits between decode and the ALU operand mux, with a valid/ready handshake on both sides and a registered output.

Parameters:
IMM_W, 4, width of the immediate field carried by one instruction.
DATA_W, 8, datapath/output width. Must be a multiple of IMM_W and greater than IMM_W (elaboration-time assertion).
MAX_PFX, DATA_W/IMM_W-1, derived localparam: the number of prefix beats that fit without loss.

Ports:
clk  in  1  clock. Single clock domain; all state updates on the rising edge.
rst_n  in  1  reset, asynchronous, active-low.
flush  in  1  synchronous clear of prefix state and output register (pipeline flush/branch).
in_valid  in  1  decode presents an immediate beat.
in_ready  out  1  beat accepted when in_valid && in_ready.
imm_in  in  IMM_W  raw immediate field.
mode  in  2  imm_mode_t: IMM_ZEXT, IMM_SEXT, IMM_PFX.
out_valid  out  1  extended immediate available.
out_ready  in  1  consumer accepts result.
imm_out  out  DATA_W  extended immediate.
pfx_ovf  out  1  qualifies imm_out: more than MAX_PFX prefixes preceded this result.

Behaviour:
- Reset (rst_n low, asynchronous): acc=0, cnt=0, ovf=0, out_valid=0, imm_out=0, pfx_ovf=0.
- Handshake:
  - in_ready = !flush && (!out_valid || out_ready).
  - The output stage is a single register. Throughput is one result per cycle under no backpressure.
- IMM_PFX beat accepted:
  - acc <= (acc << IMM_W) | imm_in, truncated to DATA_W-IMM_W bits.
  - If cnt < MAX_PFX, cnt increments; otherwise cnt holds and ovf <= 1. The oldest chunk is discarded.
  - No output is produced; out_valid is unaffected except by normal out_ready consumption.
- IMM_ZEXT/IMM_SEXT beat accepted (final beat):
  - Combined value v = {acc, imm_in}, effective width EW = (cnt+1)*IMM_W.
  - ZEXT: bits above EW are 0.
  - SEXT: bits above EW replicate v[EW-1].
  - If EW = DATA_W, no extension applies.
  - Next cycle: out_valid=1, imm_out=result, pfx_ovf=ovf.
  - acc, cnt and ovf clear in the same edge.
- Latency: exactly 1 cycle from an accepted final beat to out_valid.
- Output consumption:
  - out_valid && out_ready with no new final beat: out_valid <= 0.
  - imm_out holds its last value.
- Reserved mode 2'b11 is treated as IMM_ZEXT.
- Simultaneous consume and accept: out_ready=1 with a new final beat on the same edge loads the new result; out_valid stays 1.
- Backpressure: while out_valid && !out_ready, in_ready=0. Prefix beats are also stalled, keeping ordering simple.
- flush:
  - Takes priority over everything.
  - Next edge: acc=0, cnt=0, ovf=0, out_valid=0.
  - in_ready=0 during flush, so a concurrent beat is not accepted.
- Reset mid-prefix discards the partial accumulation. The first post-reset final beat behaves as if no prefix was seen.

Decomposition:
- Package imm_pkg holds:
  - typedef enum logic [1:0] imm_mode_t {IMM_ZEXT=2'b00, IMM_SEXT=2'b01, IMM_PFX=2'b10}.
  - Default width constants IMM_W_DEF=4 and DATA_W_DEF=8, shared with decode and the golden model.
- Sub-module imm_ext_core: purely combinational, computes the result from acc, cnt, imm_in and a sign flag.
- The top level holds the accumulator, counter, ovf flag, handshake and output register.

Test Plan (IMM_W=4, DATA_W=8):
1. After reset, ZEXT imm_in=4'hA, out_ready=1 -> next cycle out_valid=1, imm_out=8'h0A, pfx_ovf=0. The following cycle out_valid=0.
2. SEXT 4'hA, then SEXT 4'h5 back-to-back -> imm_out 8'hFA then 8'h05 on consecutive cycles, out_valid held high.
3. PFX 4'h8, then SEXT 4'h3 -> no output after the PFX beat; then imm_out=8'h83 (EW=8, no extension), pfx_ovf=0.
4. PFX 4'h1, PFX 4'h2, ZEXT 4'h3 -> imm_out=8'h23, pfx_ovf=1. A following ZEXT 4'h4 gives 8'h04, pfx_ovf=0.
5. out_ready=0, ZEXT 4'h1 then ZEXT 4'h2 presented:
   - 8'h01 is held and in_ready=0 until out_ready=1.
   - 8'h02 follows with no loss or reordering.
6. Case (a), PFX 4'hF then flush then SEXT 4'h3 -> 8'h03. Case (b), PFX 4'hF then rst_n pulsed low mid-cycle then ZEXT 4'h3 -> outputs zero immediately on reset, then 8'h03.
